psw_reg: RTL and testbench

PSW_REG -- requirements
Module: psw_reg

---
 rtl/psw_reg_pkg.sv | 34 +++
 rtl/psw_reg_cond_eval.sv | 41 ++++
 rtl/psw_reg.sv | 92 +++++++++
 tb/tb_psw_reg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/psw_reg_pkg.sv
// Shared CPU definitions for the PSW block: flag bit positions, branch
// condition encodings and the per-flag JK update rule.
package psw_reg_pkg;

  localparam int unsigned PSW_N = 3;
  localparam int unsigned PSW_Z = 2;
  localparam int unsigned PSW_V = 1;
  localparam int unsigned PSW_C = 0;

  localparam logic [3:0] CC_AL = 4'd0;
  localparam logic [3:0] CC_EQ = 4'd1;
  localparam logic [3:0] CC_NE = 4'd2;
  localparam logic [3:0] CC_MI = 4'd3;
  localparam logic [3:0] CC_PL = 4'd4;
  localparam logic [3:0] CC_CS = 4'd5;
  localparam logic [3:0] CC_CC = 4'd6;
  localparam logic [3:0] CC_VS = 4'd7;
  localparam logic [3:0] CC_VC = 4'd8;
  localparam logic [3:0] CC_LT = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LE = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_HI = 4'd13;
  localparam logic [3:0] CC_LS = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  // Bitwise JK flip-flop characteristic equation: Q+ = J&~Q | ~K&Q
  function automatic logic [3:0] jk_apply(input logic [3:0] q,
                                          input logic [3:0] j,
                                          input logic [3:0] k);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/psw_reg_cond_eval.sv
// Combinational branch-condition evaluator over the NZVC flags.
module psw_cond_eval
  import psw_reg_pkg::*;
(
  input  logic [3:0] nzvc,
  input  logic [3:0] cond_code,
  output logic       taken
);

  logic n, z, v, c, lt;

  assign n  = nzvc[PSW_N];
  assign z  = nzvc[PSW_Z];
  assign v  = nzvc[PSW_V];
  assign c  = nzvc[PSW_C];
  assign lt = n ^ v;

  always_comb begin
    taken = 1'b0;
    case (cond_code)
      CC_AL: taken = 1'b1;
      CC_EQ: taken = z;
      CC_NE: taken = ~z;
      CC_MI: taken = n;
      CC_PL: taken = ~n;
      CC_CS: taken = c;
      CC_CC: taken = ~c;
      CC_VS: taken = v;
      CC_VC: taken = ~v;
      CC_LT: taken = lt;
      CC_GE: taken = ~lt;
      CC_LE: taken = z | lt;
      CC_GT: taken = ~(z | lt);
      CC_HI: taken = ~c & ~z;
      CC_LS: taken = c | z;
      CC_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/psw_reg.sv
// Processor status word: JK-updated NZVC flags, LIFO shadow stack for nested
// interrupts, sticky stack error flags and a registered branch evaluator.
module psw_reg
  import psw_reg_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         J_N,
  input  logic                         K_N,
  input  logic                         J_Z,
  input  logic                         K_Z,
  input  logic                         J_V,
  input  logic                         K_V,
  input  logic                         J_C,
  input  logic                         K_C,
  input  logic                         save,
  input  logic                         restore,
  input  logic                         cond_eval,
  input  logic [3:0]                   cond_code,
  output logic                         N,
  output logic                         Z,
  output logic                         V,
  output logic                         C,
  output logic [3:0]                   psw_out,
  output logic                         branch_taken,
  output logic                         branch_valid,
  output logic [$clog2(DEPTH+1)-1:0]   depth_cnt,
  output logic                         err_ovf,
  output logic                         err_unf
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [3:0]    flags;
  logic [3:0]    jk_next;
  logic [3:0]    stack [2**AW];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          push, pop, ovf_evt, unf_evt, cond_taken;

  assign jk_next = jk_apply(flags, {J_N, J_Z, J_V, J_C}, {K_N, K_Z, K_V, K_C});

  // save and restore together cancel: neither a stack move nor an error
  assign push    = save & ~restore & (depth_cnt != FULL);
  assign pop     = restore & ~save & (depth_cnt != '0);
  assign ovf_evt = save & ~restore & (depth_cnt == FULL);
  assign unf_evt = restore & ~save & (depth_cnt == '0);

  assign wr_idx = AW'(depth_cnt);
  assign rd_idx = AW'(depth_cnt - DW'(1));

  psw_cond_eval u_cond (
    .nzvc      (flags),
    .cond_code (cond_code),
    .taken     (cond_taken)
  );

  // Shadow entries are left untouched by reset; depth_cnt alone tracks validity
  always_ff @(posedge clk) begin
    if (!rst && push) stack[wr_idx] <= flags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags        <= '0;
      depth_cnt    <= '0;
      branch_taken <= 1'b0;
      branch_valid <= 1'b0;
      err_ovf      <= 1'b0;
      err_unf      <= 1'b0;
    end else begin
      flags <= pop ? stack[rd_idx] : jk_next;
      if (push)     depth_cnt <= depth_cnt + DW'(1);
      else if (pop) depth_cnt <= depth_cnt - DW'(1);
      if (ovf_evt) err_ovf <= 1'b1;
      if (unf_evt) err_unf <= 1'b1;
      branch_valid <= cond_eval;
      if (cond_eval) branch_taken <= cond_taken;
    end
  end

  assign N       = flags[PSW_N];
  assign Z       = flags[PSW_Z];
  assign V       = flags[PSW_V];
  assign C       = flags[PSW_C];
  assign psw_out = flags;

endmodule

// File: tb/tb_psw_reg.sv
// Directed and randomized bench for psw_reg against a queue-based PSW model.
module tb_psw_reg;

  localparam int unsigned DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst, J_N, K_N, J_Z, K_Z, J_V, K_V, J_C, K_C;
  logic       save, restore, cond_eval;
  logic [3:0] cond_code;
  logic       N, Z, V, C, branch_taken, branch_valid, err_ovf, err_unf;
  logic [3:0] psw_out;
  logic [1:0] depth_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] m_flags;
  logic [3:0] m_q [$];
  logic       m_taken, m_valid, m_ovf, m_unf;

  psw_reg #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .J_N(J_N), .K_N(K_N), .J_Z(J_Z), .K_Z(K_Z),
    .J_V(J_V), .K_V(K_V), .J_C(J_C), .K_C(K_C),
    .save(save), .restore(restore), .cond_eval(cond_eval), .cond_code(cond_code),
    .N(N), .Z(Z), .V(V), .C(C), .psw_out(psw_out),
    .branch_taken(branch_taken), .branch_valid(branch_valid),
    .depth_cnt(depth_cnt), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  function automatic logic cond_ref(input logic [3:0] f, input int code);
    logic n, z, v, c, lt;
    logic tbl [16];
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    lt = (n != v);
    tbl = '{1'b1, z, !z, n, !n, c, !c, v, !v, lt, !lt, z || lt, !(z || lt),
            !c && !z, c || z, 1'b0};
    return tbl[code];
  endfunction

  function automatic logic jk_bit(input logic q, input logic j, input logic k);
    if (j && k) return !q;
    if (j)      return 1'b1;
    if (k)      return 1'b0;
    return q;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic [3:0] pre, nxt, j, k;
    pre = m_flags;
    j = {J_N, J_Z, J_V, J_C};
    k = {K_N, K_Z, K_V, K_C};
    for (int b = 0; b < 4; b++) nxt[b] = jk_bit(pre[b], j[b], k[b]);
    if (rst) begin
      m_flags = 4'h0; m_q.delete();
      m_taken = 1'b0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      return;
    end
    if (restore && !save) begin
      if (m_q.size() > 0) m_flags = m_q.pop_back();
      else begin m_unf = 1'b1; m_flags = nxt; end
    end else begin
      if (save && !restore) begin
        if (m_q.size() < DEPTH) m_q.push_back(pre);
        else m_ovf = 1'b1;
      end
      m_flags = nxt;
    end
    m_valid = cond_eval;
    if (cond_eval) m_taken = cond_ref(pre, int'(cond_code));
  endtask

  task automatic check_all();
    check("psw_out", {4'h0, psw_out}, {4'h0, m_flags});
    check("nzvc_bits", {4'h0, N, Z, V, C}, {4'h0, m_flags});
    check("depth_cnt", {6'h0, depth_cnt}, 8'(m_q.size()));
    check("branch_taken", {7'h0, branch_taken}, {7'h0, m_taken});
    check("branch_valid", {7'h0, branch_valid}, {7'h0, m_valid});
    check("err_ovf", {7'h0, err_ovf}, {7'h0, m_ovf});
    check("err_unf", {7'h0, err_unf}, {7'h0, m_unf});
  endtask

  task automatic drive(input logic r, input logic [3:0] j, input logic [3:0] k,
                       input logic s, input logic rs, input logic ce, input logic [3:0] cc);
    rst = r; save = s; restore = rs; cond_eval = ce; cond_code = cc;
    {J_N, J_Z, J_V, J_C} = j;
    {K_N, K_Z, K_V, K_C} = k;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    m_flags = 4'h0; m_taken = 1'b0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    // reset with every other input active
    drive(1, 4'hF, 4'h0, 1, 1, 1, 4'd0);
    check("reset_psw", {4'h0, psw_out}, 8'h00);
    check("reset_misc", {3'h0, depth_cnt, branch_valid, err_ovf, err_unf}, 8'h00);

    // JK set, toggle, set
    drive(0, 4'b0100, 4'b0000, 0, 0, 0, 4'd0);
    check("jk_set_z", {7'h0, Z}, 8'h01);
    drive(0, 4'b0100, 4'b0100, 0, 0, 0, 4'd0);
    check("jk_toggle_z", {7'h0, Z}, 8'h00);
    drive(0, 4'b0001, 4'b0000, 0, 0, 0, 4'd0);
    check("jk_set_c", {4'h0, psw_out}, 8'h01);

    // save with simultaneous JK, then restore ignoring JK
    drive(0, 4'b1010, 4'b0101, 0, 0, 0, 4'd0);
    drive(0, 4'b0001, 4'b0000, 1, 0, 0, 4'd0);
    check("save_jk_psw", {4'h0, psw_out}, 8'h0B);
    check("save_depth", {6'h0, depth_cnt}, 8'h01);
    drive(0, 4'b0101, 4'b1111, 0, 1, 0, 4'd0);
    check("restore_psw", {4'h0, psw_out}, 8'h0A);
    check("restore_depth", {6'h0, depth_cnt}, 8'h00);

    // overflow / underflow: pushes 1010 then 0110, third save overflows
    drive(0, 4'b0100, 4'b1000, 1, 0, 0, 4'd0);
    drive(0, 4'b0000, 4'b0000, 1, 0, 0, 4'd0);
    drive(0, 4'b0000, 4'b0000, 1, 0, 0, 4'd0);
    check("ovf_depth", {6'h0, depth_cnt}, 8'h02);
    check("ovf_flag", {7'h0, err_ovf}, 8'h01);
    drive(0, 4'b0000, 4'b0000, 0, 1, 0, 4'd0);
    check("pop1_psw", {4'h0, psw_out}, 8'h06);
    drive(0, 4'b0000, 4'b0000, 0, 1, 0, 4'd0);
    check("pop2_first_saved", {4'h0, psw_out}, 8'h0A);
    drive(0, 4'b0000, 4'b0000, 0, 1, 0, 4'd0);
    check("unf_depth", {6'h0, depth_cnt}, 8'h00);
    check("unf_flag", {7'h0, err_unf}, 8'h01);

    // branch evaluation on NZVC=1000
    drive(1, 4'h0, 4'h0, 0, 0, 0, 4'd0);
    drive(0, 4'b1000, 4'b0111, 0, 0, 0, 4'd0);
    drive(0, 4'b0000, 4'b0000, 0, 0, 1, 4'd9);
    check("br_lt_valid", {7'h0, branch_valid}, 8'h01);
    check("br_lt_taken", {7'h0, branch_taken}, 8'h01);
    drive(0, 4'b0000, 4'b0000, 0, 0, 1, 4'd12);
    check("br_gt_taken", {7'h0, branch_taken}, 8'h00);
    drive(0, 4'b0000, 4'b0000, 0, 0, 1, 4'd0);
    drive(0, 4'b0000, 4'b0000, 0, 0, 0, 4'd15);
    check("br_idle_valid", {7'h0, branch_valid}, 8'h00);
    check("br_idle_hold", {7'h0, branch_taken}, 8'h01);

    // simultaneous save and restore at depth 1
    drive(0, 4'b0000, 4'b1000, 1, 0, 0, 4'd0);
    drive(0, 4'b1000, 4'b0000, 1, 1, 0, 4'd0);
    check("simul_depth", {6'h0, depth_cnt}, 8'h01);
    check("simul_n", {7'h0, N}, 8'h01);
    check("simul_no_err", {6'h0, err_ovf, err_unf}, 8'h00);

    // reset mid-nesting
    drive(0, 4'b0000, 4'b0000, 1, 0, 0, 4'd0);
    drive(0, 4'b0000, 4'b0000, 1, 0, 1, 4'd0);
    check("nest_depth", {6'h0, depth_cnt}, 8'h02);
    check("nest_ovf", {7'h0, err_ovf}, 8'h01);
    drive(1, 4'b1111, 4'b0000, 0, 1, 1, 4'd0);
    check("rst_mid_psw", {4'h0, psw_out}, 8'h00);
    check("rst_mid_misc", {2'h0, depth_cnt, branch_taken, branch_valid, err_ovf, err_unf}, 8'h00);
    drive(0, 4'b0000, 4'b0000, 0, 1, 0, 4'd0);
    check("rst_then_unf", {7'h0, err_unf}, 8'h01);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 31) == 0, 4'($urandom), 4'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
